regfile_param: RTL and testbench
================================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 The module SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2^ADDR_W registers.
REQ-003 The module SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads as zero and ignores writes.
REQ-004 The module SHALL have port Clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-005 The module SHALL have port Resetin, input, 1 bit: synchronous, active-low reset, sampled on the Clk rising edge.
REQ-006 The module SHALL have port Ard1, input, ADDR_W bits, read address for port 1.
REQ-007 The module SHALL have port Ard2, input, ADDR_W bits, read address for port 2.
REQ-008 The module SHALL have port Awr, input, ADDR_W bits, write address.
REQ-009 The module SHALL have port Din, input, DATA_W bits, write data.
REQ-010 The module SHALL have port WrEn, input, 1 bit, write enable.
REQ-011 The module SHALL have port ClrReq, input, 1 bit, single-cycle request for a full-file clear.
REQ-012 The module SHALL have port Dout1, output, DATA_W bits, registered read data for port 1.
REQ-013 The module SHALL have port Dout2, output, DATA_W bits, registered read data for port 2.
REQ-014 The module SHALL have port Ready, output, 1 bit, high when the file accepts reads and writes.

Function
REQ-015 The FSM SHALL have two states: CLEAR (sequential zeroing) and READY (normal operation).
REQ-016 In CLEAR, each rising edge SHALL zero entry clr_cnt and increment clr_cnt; the edge that zeroes entry DEPTH-1 SHALL move the FSM to READY, with Ready=1 after that edge.
REQ-017 In CLEAR, WrEn SHALL be ignored, Dout1 and Dout2 SHALL be 0, and ClrReq SHALL be ignored.
REQ-018 In READY, ClrReq=1 at an edge SHALL move the FSM to CLEAR with clr_cnt=0 and Ready=0; a write presented on that same edge SHALL be discarded.
REQ-019 In READY, WrEn=1 at an edge SHALL store Din into entry Awr, except Awr=0 when ZERO_REG=1.
REQ-020 Read latency SHALL be one cycle: at each READY edge, DoutN takes the contents of entry ArdN.
REQ-021 Write-first bypass: if WrEn=1 and Awr==ArdN on the same READY edge and the write is accepted, DoutN SHALL take Din.
REQ-022 With ZERO_REG=1, a read of address 0 SHALL return 0, including when bypass conditions are met.
REQ-023 Both read ports SHALL be independent; Ard1==Ard2 SHALL return identical data on both.
REQ-024 clr_cnt SHALL be ADDR_W bits wide and SHALL NOT wrap past DEPTH-1 while in CLEAR.

Reset
REQ-025 Resetin=0 at an edge SHALL set FSM=CLEAR, clr_cnt=0, Ready=0, Dout1=0, Dout2=0, regardless of the current state or of any other input.
REQ-026 Reset during an ongoing CLEAR SHALL restart the clear from entry 0.
REQ-027 Full zeroing SHALL complete DEPTH rising edges after the first edge with Resetin=1; register contents need not be zeroed by reset itself.

Verification
REQ-028 Reset release, defaults: hold Resetin=0 for 2 edges, then 1 -> Ready=0 for 31 edges and Ready=1 after the 32nd; any read returns 0.
REQ-029 Write, then read: Ready=1; write 0xDEADBEEF to reg 7; next cycle Ard1=7 -> Dout1=0xDEADBEEF one edge later.
REQ-030 Bypass and zero register: WrEn=1, Awr=Ard2=9, Din=0x12345678 -> Dout2=0x12345678 on the same edge; write 0xFFFFFFFF to reg 0 -> reading reg 0 returns 0.
REQ-031 ClrReq with simultaneous write: ClrReq=1 with WrEn=1, Awr=3, Din=5 -> Ready=0 next cycle and writes are ignored for 32 edges; afterwards reg 3 and reg 7 read 0.
REQ-032 Reset in mid-clear: Resetin=0 at clear count 10 -> on release, Ready stays 0 for 32 further edges.
REQ-033 Parameter sweep: DATA_W=16, ADDR_W=3, ZERO_REG=0 -> Ready rises after 8 edges, and reg 0 is writable (write 0xA5A5, read 0xA5A5).

Source files
------------

// File: rtl/regfile_param_if.sv
// Bus bundle for regfile_param: two read ports, one write port, clear request and status.
interface regfile_param_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] Ard1;
   logic [ADDR_W-1:0] Ard2;
   logic [ADDR_W-1:0] Awr;
   logic [DATA_W-1:0] Din;
   logic              WrEn;
   logic              ClrReq;
   logic [DATA_W-1:0] Dout1;
   logic [DATA_W-1:0] Dout2;
   logic              Ready;

   modport master (
      output Ard1, Ard2, Awr, Din, WrEn, ClrReq,
      input  Dout1, Dout2, Ready
   );

   modport slave (
      input  Ard1, Ard2, Awr, Din, WrEn, ClrReq,
      output Dout1, Dout2, Ready
   );
endinterface

// File: rtl/regfile_param.sv
// Parameterised 2-read/1-write register file with registered reads, write-first bypass,
// optional hardwired-zero register 0 and a sequential clear FSM entered on reset or ClrReq.
module regfile_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic           Clk,
   input  logic           Resetin,
   regfile_param_if.slave rf
);

   localparam int              DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);
   localparam bit              ZERO_IS  = (ZERO_REG != 0);

   typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_clr_cnt;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [DATA_W-1:0]   r_dout1;
   logic [DATA_W-1:0]   r_dout2;
   logic                w_wr_acc;
   logic                w_clr_last;

   // Register 0 masking wins over bypass so a discarded write never leaks to a reader.
   function automatic logic [DATA_W-1:0] read_sel(
      input logic [ADDR_W-1:0] ard,
      input logic              wr_acc,
      input logic [ADDR_W-1:0] awr,
      input logic [DATA_W-1:0] din,
      input logic [DATA_W-1:0] word
   );
      if (ZERO_IS && ard == '0) return '0;
      if (wr_acc && awr == ard) return din;
      return word;
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      w_clr_last  = (r_clr_cnt == CNT_LAST);
      w_wr_acc    = 1'b0;
      case (r_state)
         CLEAR: if (w_clr_last) w_state_nxt = READY;
         READY: begin
            if (rf.ClrReq) w_state_nxt = CLEAR;
            w_wr_acc = rf.WrEn && !rf.ClrReq && !(ZERO_IS && rf.Awr == '0);
         end
         default: w_state_nxt = CLEAR;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Resetin) r_state <= CLEAR;
      else          r_state <= w_state_nxt;
   end

   // Counter parks on the last entry instead of wrapping; ClrReq rearms it at 0.
   always_ff @(posedge Clk) begin
      if (!Resetin) begin
         r_clr_cnt <= '0;
      end else if (r_state == CLEAR) begin
         if (!w_clr_last) r_clr_cnt <= r_clr_cnt + 1'b1;
      end else if (rf.ClrReq) begin
         r_clr_cnt <= '0;
      end
   end

   always_ff @(posedge Clk) begin
      if (Resetin) begin
         if (r_state == CLEAR) r_mem[r_clr_cnt] <= '0;
         else if (w_wr_acc)    r_mem[rf.Awr]    <= rf.Din;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Resetin || r_state == CLEAR) begin
         r_dout1 <= '0;
         r_dout2 <= '0;
      end else begin
         r_dout1 <= read_sel(rf.Ard1, w_wr_acc, rf.Awr, rf.Din, r_mem[rf.Ard1]);
         r_dout2 <= read_sel(rf.Ard2, w_wr_acc, rf.Awr, rf.Din, r_mem[rf.Ard2]);
      end
   end

   assign rf.Dout1 = r_dout1;
   assign rf.Dout2 = r_dout2;
   assign rf.Ready = (r_state == READY);

endmodule

// File: tb/tb_regfile_param.sv
// Directed testbench for regfile_param: default instance plus a 16-bit/8-entry instance without a zero register.
module tb_regfile_param;

   logic Clk;
   logic Resetin;
   int   n_cmp;
   int   n_bad;

   regfile_param_if #(.DATA_W(32), .ADDR_W(5)) bus_a ();
   regfile_param_if #(.DATA_W(16), .ADDR_W(3)) bus_b ();

   regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_dut_a (
      .Clk     (Clk),
      .Resetin (Resetin),
      .rf      (bus_a.slave)
   );

   regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) u_dut_b (
      .Clk     (Clk),
      .Resetin (Resetin),
      .rf      (bus_b.slave)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Resetin = 1'b0;
      tick();
      tick();
      n_cmp++; if (bus_a.Ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got=%0b exp=0", bus_a.Ready); end
      n_cmp++; if (bus_a.Dout1 !== 32'h0) begin n_bad++; $display("FAIL rst_dout1 got=%h exp=0", bus_a.Dout1); end
      n_cmp++; if (bus_a.Dout2 !== 32'h0) begin n_bad++; $display("FAIL rst_dout2 got=%h exp=0", bus_a.Dout2); end
      Resetin = 1'b1;
      for (int i = 1; i <= 31; i++) begin
         tick();
         n_cmp++; if (bus_a.Ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready_early edge=%0d got=%0b exp=0", i, bus_a.Ready); end
         if (i == 7) begin
            n_cmp++; if (bus_b.Ready !== 1'b0) begin n_bad++; $display("FAIL b_ready_early got=%0b exp=0", bus_b.Ready); end
         end
         if (i == 8) begin
            n_cmp++; if (bus_b.Ready !== 1'b1) begin n_bad++; $display("FAIL b_ready_rise got=%0b exp=1", bus_b.Ready); end
         end
      end
      tick();
      n_cmp++; if (bus_a.Ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_rise got=%0b exp=1", bus_a.Ready); end
      bus_a.Ard1 = 5'd5;
      bus_a.Ard2 = 5'd31;
      tick();
      n_cmp++; if (bus_a.Dout1 !== 32'h0) begin n_bad++; $display("FAIL rst_read5 got=%h exp=0", bus_a.Dout1); end
      n_cmp++; if (bus_a.Dout2 !== 32'h0) begin n_bad++; $display("FAIL rst_read31 got=%h exp=0", bus_a.Dout2); end
   endtask

   task automatic test_write_read();
      bus_a.WrEn = 1'b1; bus_a.Awr = 5'd7; bus_a.Din = 32'hDEADBEEF;
      bus_a.Ard1 = 5'd1; bus_a.Ard2 = 5'd2;
      tick();
      bus_a.WrEn = 1'b0; bus_a.Ard1 = 5'd7; bus_a.Ard2 = 5'd7;
      tick();
      n_cmp++; if (bus_a.Dout1 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_rd_dout1 got=%h exp=deadbeef", bus_a.Dout1); end
      n_cmp++; if (bus_a.Dout2 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_rd_same_addr got=%h exp=deadbeef", bus_a.Dout2); end
   endtask

   task automatic test_bypass_zero();
      bus_a.WrEn = 1'b1; bus_a.Awr = 5'd9; bus_a.Din = 32'h12345678;
      bus_a.Ard1 = 5'd7; bus_a.Ard2 = 5'd9;
      tick();
      n_cmp++; if (bus_a.Dout2 !== 32'h12345678) begin n_bad++; $display("FAIL bypass_dout2 got=%h exp=12345678", bus_a.Dout2); end
      n_cmp++; if (bus_a.Dout1 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL bypass_indep_dout1 got=%h exp=deadbeef", bus_a.Dout1); end
      bus_a.Awr = 5'd0; bus_a.Din = 32'hFFFFFFFF; bus_a.Ard1 = 5'd0; bus_a.Ard2 = 5'd0;
      tick();
      n_cmp++; if (bus_a.Dout1 !== 32'h0) begin n_bad++; $display("FAIL zero_bypass_dout1 got=%h exp=0", bus_a.Dout1); end
      n_cmp++; if (bus_a.Dout2 !== 32'h0) begin n_bad++; $display("FAIL zero_bypass_dout2 got=%h exp=0", bus_a.Dout2); end
      bus_a.WrEn = 1'b0; bus_a.Ard2 = 5'd9;
      tick();
      n_cmp++; if (bus_a.Dout1 !== 32'h0) begin n_bad++; $display("FAIL zero_read got=%h exp=0", bus_a.Dout1); end
      n_cmp++; if (bus_a.Dout2 !== 32'h12345678) begin n_bad++; $display("FAIL bypass_stored got=%h exp=12345678", bus_a.Dout2); end
   endtask

   task automatic test_clear_req();
      bus_a.ClrReq = 1'b1; bus_a.WrEn = 1'b1; bus_a.Awr = 5'd3; bus_a.Din = 32'd5;
      bus_a.Ard1 = 5'd7; bus_a.Ard2 = 5'd9;
      tick();
      n_cmp++; if (bus_a.Ready !== 1'b0) begin n_bad++; $display("FAIL clr_ready_drop got=%0b exp=0", bus_a.Ready); end
      bus_a.ClrReq = 1'b0;
      tick();
      n_cmp++; if (bus_a.Dout1 !== 32'h0) begin n_bad++; $display("FAIL clr_dout1_zero got=%h exp=0", bus_a.Dout1); end
      n_cmp++; if (bus_a.Dout2 !== 32'h0) begin n_bad++; $display("FAIL clr_dout2_zero got=%h exp=0", bus_a.Dout2); end
      for (int i = 2; i <= 31; i++) begin
         bus_a.ClrReq = (i == 20);
         tick();
      end
      bus_a.ClrReq = 1'b0;
      n_cmp++; if (bus_a.Ready !== 1'b0) begin n_bad++; $display("FAIL clr_ready_early got=%0b exp=0", bus_a.Ready); end
      tick();
      n_cmp++; if (bus_a.Ready !== 1'b1) begin n_bad++; $display("FAIL clr_ready_rise got=%0b exp=1", bus_a.Ready); end
      bus_a.WrEn = 1'b0; bus_a.Ard1 = 5'd3; bus_a.Ard2 = 5'd7;
      tick();
      n_cmp++; if (bus_a.Dout1 !== 32'h0) begin n_bad++; $display("FAIL clr_reg3 got=%h exp=0", bus_a.Dout1); end
      n_cmp++; if (bus_a.Dout2 !== 32'h0) begin n_bad++; $display("FAIL clr_reg7 got=%h exp=0", bus_a.Dout2); end
   endtask

   task automatic test_mid_clear_reset();
      bus_a.ClrReq = 1'b1;
      tick();
      bus_a.ClrReq = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      Resetin = 1'b0;
      tick();
      n_cmp++; if (bus_a.Ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready got=%0b exp=0", bus_a.Ready); end
      Resetin = 1'b1;
      for (int i = 0; i < 31; i++) tick();
      n_cmp++; if (bus_a.Ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready_early got=%0b exp=0", bus_a.Ready); end
      tick();
      n_cmp++; if (bus_a.Ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready_rise got=%0b exp=1", bus_a.Ready); end
   endtask

   task automatic test_back_to_back();
      bus_a.WrEn = 1'b1; bus_a.Awr = 5'd10; bus_a.Din = 32'hAAAA0001;
      bus_a.Ard1 = 5'd10; bus_a.Ard2 = 5'd11;
      tick();
      n_cmp++; if (bus_a.Dout1 !== 32'hAAAA0001) begin n_bad++; $display("FAIL b2b_bypass10 got=%h exp=aaaa0001", bus_a.Dout1); end
      n_cmp++; if (bus_a.Dout2 !== 32'h0) begin n_bad++; $display("FAIL b2b_read11_old got=%h exp=0", bus_a.Dout2); end
      bus_a.Awr = 5'd11; bus_a.Din = 32'hBBBB0002;
      tick();
      n_cmp++; if (bus_a.Dout1 !== 32'hAAAA0001) begin n_bad++; $display("FAIL b2b_read10 got=%h exp=aaaa0001", bus_a.Dout1); end
      n_cmp++; if (bus_a.Dout2 !== 32'hBBBB0002) begin n_bad++; $display("FAIL b2b_bypass11 got=%h exp=bbbb0002", bus_a.Dout2); end
      bus_a.WrEn = 1'b0;
      tick();
      n_cmp++; if (bus_a.Dout2 !== 32'hBBBB0002) begin n_bad++; $display("FAIL b2b_read11 got=%h exp=bbbb0002", bus_a.Dout2); end
   endtask

   task automatic test_param_sweep();
      n_cmp++; if (bus_b.Ready !== 1'b1) begin n_bad++; $display("FAIL b_ready got=%0b exp=1", bus_b.Ready); end
      bus_b.WrEn = 1'b1; bus_b.Awr = 3'd0; bus_b.Din = 16'hA5A5;
      bus_b.Ard1 = 3'd7; bus_b.Ard2 = 3'd0;
      tick();
      n_cmp++; if (bus_b.Dout2 !== 16'hA5A5) begin n_bad++; $display("FAIL b_reg0_bypass got=%h exp=a5a5", bus_b.Dout2); end
      bus_b.Awr = 3'd7; bus_b.Din = 16'h1234; bus_b.Ard1 = 3'd0; bus_b.Ard2 = 3'd6;
      tick();
      n_cmp++; if (bus_b.Dout1 !== 16'hA5A5) begin n_bad++; $display("FAIL b_reg0_read got=%h exp=a5a5", bus_b.Dout1); end
      bus_b.WrEn = 1'b0; bus_b.Ard2 = 3'd7;
      tick();
      n_cmp++; if (bus_b.Dout2 !== 16'h1234) begin n_bad++; $display("FAIL b_reg7_read got=%h exp=1234", bus_b.Dout2); end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      Resetin = 1'b0;
      bus_a.Ard1 = '0; bus_a.Ard2 = '0; bus_a.Awr = '0; bus_a.Din = '0;
      bus_a.WrEn = 1'b0; bus_a.ClrReq = 1'b0;
      bus_b.Ard1 = '0; bus_b.Ard2 = '0; bus_b.Awr = '0; bus_b.Din = '0;
      bus_b.WrEn = 1'b0; bus_b.ClrReq = 1'b0;
      test_reset();
      test_write_read();
      test_bypass_zero();
      test_clear_req();
      test_mid_clear_reset();
      test_back_to_back();
      test_param_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
